// File: rtl/i2c_codec_pkg.sv
// Shared types and constants for the WM8731 control-port I2C responder.
package i2c_codec_pkg;

  localparam logic [6:0] WM8731_ADDR = 7'b0011010;
  localparam logic [6:0] REG_RESET   = 7'h0F;
  localparam logic [6:0] REG_ACTIVE  = 7'h09;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_A,
    ST_BYTE1,
    ST_ACK_1,
    ST_BYTE2,
    ST_ACK_2,
    ST_WAIT_STOP,
    ST_IGNORE
  } state_t;

  typedef struct packed {
    logic [6:0] reg_addr;
    logic [8:0] reg_data;
  } frame_t;

  // States in which SCL rising edges shift a data bit into the byte register.
  function automatic logic is_byte_state(input state_t s);
    return (s == ST_ADDR) || (s == ST_BYTE1) || (s == ST_BYTE2);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer with single-cycle START, STOP, SCL-rise and SCL-fall pulses.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda_s,
  output logic o_start,
  output logic o_stop,
  output logic o_scl_rise,
  output logic o_scl_fall
);

  logic [SYNC_STAGES-1:0] scl_ff;
  logic [SYNC_STAGES-1:0] sda_ff;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_now;
  logic                   sda_now;

  // Flops reset to the idle bus level so leaving reset on an idle bus is silent.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      scl_ff <= '1;
      sda_ff <= '1;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[SYNC_STAGES-2:0], i_scl};
      sda_ff <= {sda_ff[SYNC_STAGES-2:0], i_sda};
      scl_d  <= scl_ff[SYNC_STAGES-1];
      sda_d  <= sda_ff[SYNC_STAGES-1];
    end
  end

  assign scl_now    = scl_ff[SYNC_STAGES-1];
  assign sda_now    = sda_ff[SYNC_STAGES-1];
  assign o_sda_s    = sda_now;
  assign o_start    = scl_now & scl_d & sda_d & ~sda_now;
  assign o_stop     = scl_now & scl_d & ~sda_d & sda_now;
  assign o_scl_rise = scl_now & ~scl_d;
  assign o_scl_fall = ~scl_now & scl_d;

endmodule

// File: rtl/i2c_codec_responder.sv
// WM8731 write-only I2C control-port responder: ACKs {DEV_ADDR,W}, decodes 3-byte frames.
// Optional register shadow with combinational read port: define I2C_RESP_SHADOW_EN.
module i2c_codec_responder
  import i2c_codec_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = WM8731_ADDR,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_REGS    = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic       o_wr_valid,
  output logic [6:0] o_reg_addr,
  output logic [8:0] o_reg_data,
  output logic       o_busy,
  output logic [7:0] o_nack_cnt
`ifdef I2C_RESP_SHADOW_EN
  ,
  input  logic [6:0] i_rd_addr,
  output logic [8:0] o_rd_data,
  output logic [0:0] o_active
`endif
);

  if (SYNC_STAGES < 2 || NUM_REGS < 10 || NUM_REGS > 128) begin : g_param_check
    $error("i2c_codec_responder: SYNC_STAGES must be >= 2 and NUM_REGS in 10..128");
  end

  logic   sda_s;
  logic   start_p;
  logic   stop_p;
  logic   scl_rise;
  logic   scl_fall;

  state_t     state;
  logic [2:0] bit_cnt;
  logic       byte_done;
  logic [7:0] shift_reg;
  logic [7:0] hi_byte;
  frame_t     frame;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_scl      (i_scl),
    .i_sda      (i_sda),
    .o_sda_s    (sda_s),
    .o_start    (start_p),
    .o_stop     (stop_p),
    .o_scl_rise (scl_rise),
    .o_scl_fall (scl_fall)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      byte_done  <= 1'b0;
      shift_reg  <= '0;
      hi_byte    <= '0;
      frame      <= '0;
      o_sda_oe   <= 1'b0;
      o_wr_valid <= 1'b0;
      o_reg_addr <= '0;
      o_reg_data <= '0;
      o_busy     <= 1'b0;
      o_nack_cnt <= '0;
    end else begin
      o_wr_valid <= 1'b0;

      if (scl_rise && is_byte_state(state)) begin
        shift_reg <= {shift_reg[6:0], sda_s};
        bit_cnt   <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) byte_done <= 1'b1;
      end

      // Byte and ACK boundaries are all taken on the SCL falling edge.
      if (scl_fall) begin
        case (state)
          ST_ADDR: begin
            if (byte_done) begin
              byte_done <= 1'b0;
              if (shift_reg == {DEV_ADDR, 1'b0}) begin
                state    <= ST_ACK_A;
                o_sda_oe <= 1'b1;
              end else begin
                state <= ST_IGNORE;
                if (o_nack_cnt != 8'hFF) o_nack_cnt <= o_nack_cnt + 8'd1;
              end
            end
          end
          ST_BYTE1: begin
            if (byte_done) begin
              byte_done <= 1'b0;
              hi_byte   <= shift_reg;
              state     <= ST_ACK_1;
              o_sda_oe  <= 1'b1;
            end
          end
          ST_BYTE2: begin
            if (byte_done) begin
              byte_done <= 1'b0;
              frame     <= frame_t'({hi_byte, shift_reg});
              state     <= ST_ACK_2;
              o_sda_oe  <= 1'b1;
            end
          end
          ST_ACK_A: begin
            o_sda_oe <= 1'b0;
            bit_cnt  <= '0;
            state    <= ST_BYTE1;
          end
          ST_ACK_1: begin
            o_sda_oe <= 1'b0;
            bit_cnt  <= '0;
            state    <= ST_BYTE2;
          end
          ST_ACK_2: begin
            o_sda_oe   <= 1'b0;
            o_reg_addr <= frame.reg_addr;
            o_reg_data <= frame.reg_data;
            o_wr_valid <= 1'b1;
            state      <= ST_WAIT_STOP;
          end
          default: ;
        endcase
      end

      if (start_p) begin
        state     <= ST_ADDR;
        bit_cnt   <= '0;
        byte_done <= 1'b0;
        o_sda_oe  <= 1'b0;
        o_busy    <= 1'b1;
      end else if (stop_p) begin
        state     <= ST_IDLE;
        byte_done <= 1'b0;
        o_sda_oe  <= 1'b0;
        o_busy    <= 1'b0;
      end
    end
  end

`ifdef I2C_RESP_SHADOW_EN
  localparam int unsigned AW         = $clog2(NUM_REGS);
  localparam logic [7:0]  NUM_REGS_W = 8'(NUM_REGS);

  logic [8:0] shadow [NUM_REGS];

  // A write to the codec RESET register clears the whole shadow instead of storing.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
    end else if (o_wr_valid) begin
      if (o_reg_addr == REG_RESET) begin
        for (int unsigned i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
      end else if ({1'b0, o_reg_addr} < NUM_REGS_W) begin
        shadow[o_reg_addr[AW-1:0]] <= o_reg_data;
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    if ({1'b0, i_rd_addr} < NUM_REGS_W) o_rd_data = shadow[i_rd_addr[AW-1:0]];
  end

  assign o_active = shadow[REG_ACTIVE[AW-1:0]][0];
`endif

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Directed bench for i2c_codec_responder: bus master tasks plus strobe monitor.
`timescale 1ns/1ps
module tb_i2c_codec_responder;

  localparam int Q = 40;
  localparam int H = 80;
  localparam time LAT_NS = 30;  // (SYNC_STAGES+1) clocks of 10 ns, sampled on negedge

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       sda_m;
  logic       sda_bus;
  logic       sda_oe;
  logic       wr_valid;
  logic [6:0] reg_addr;
  logic [8:0] reg_data;
  logic       busy;
  logic [7:0] nack_cnt;
`ifdef I2C_RESP_SHADOW_EN
  logic [6:0] rd_addr;
  logic [8:0] rd_data;
  logic [0:0] active;
`endif

  int checks = 0;
  int errors = 0;

  int         strobes = 0;
  int         wv_cycles = 0;
  logic       wv_prev = 1'b0;
  logic       oe_seen = 1'b0;
  time        t_scl_fall = 0;
  time        lat = 0;
  logic [6:0] cap_addr [$];
  logic [8:0] cap_data [$];

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_codec_responder #(
    .DEV_ADDR    (7'b0011010),
    .SYNC_STAGES (2),
    .NUM_REGS    (16)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_scl      (scl),
    .i_sda      (sda_bus),
    .o_sda_oe   (sda_oe),
    .o_wr_valid (wr_valid),
    .o_reg_addr (reg_addr),
    .o_reg_data (reg_data),
    .o_busy     (busy),
    .o_nack_cnt (nack_cnt)
`ifdef I2C_RESP_SHADOW_EN
    ,
    .i_rd_addr  (rd_addr),
    .o_rd_data  (rd_data),
    .o_active   (active)
`endif
  );

  always @(negedge scl) t_scl_fall = $time;

  always @(negedge clk) begin
    if (wr_valid === 1'b1) begin
      wv_cycles++;
      if (!wv_prev) begin
        strobes++;
        cap_addr.push_back(reg_addr);
        cap_data.push_back(reg_data);
        lat = $time - t_scl_fall;
      end
    end
    wv_prev = (wr_valid === 1'b1);
    if (sda_oe === 1'b1) oe_seen = 1'b1;
  end

  task automatic i2c_start();
    sda_m = 1'b1; #Q;
    scl   = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl   = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q;
    scl   = 1'b1; #Q;
    sda_m = 1'b1; #H;
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; #Q;
    scl   = 1'b1; #H;
    scl   = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; #Q;
    scl   = 1'b1; #Q;
    ack   = (sda_bus === 1'b0);
    #Q;
    scl   = 1'b0; #Q;
  endtask

  task automatic test_reset();
    rst = 1'b1; scl = 1'b1; sda_m = 1'b1;
`ifdef I2C_RESP_SHADOW_EN
    rd_addr = '0;
`endif
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (sda_oe !== 1'b0)   begin errors++; $display("FAIL reset_oe: got %b want 0", sda_oe); end
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wv: got %b want 0", wr_valid); end
    checks++; if (reg_addr !== 7'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", reg_addr); end
    checks++; if (reg_data !== 9'd0) begin errors++; $display("FAIL reset_data: got %h want 0", reg_data); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (nack_cnt !== 8'd0) begin errors++; $display("FAIL reset_nack: got %0d want 0", nack_cnt); end
  endtask

  task automatic test_single_frame();
    logic a0, a1, a2;
    int base;
    base = strobes;
    i2c_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_start: got %b want 1", busy); end
    send_byte(8'h34, a0);
    send_byte(8'h00, a1);
    send_byte(8'h97, a2);
    checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL single_acks: got %b want 111", {a0, a1, a2}); end
    checks++; if (strobes - base !== 1) begin errors++; $display("FAIL single_strobes: got %0d want 1", strobes - base); end
    checks++; if (lat !== LAT_NS) begin errors++; $display("FAIL single_latency: got %0t want %0t", lat, LAT_NS); end
    i2c_stop();
    checks++; if (reg_addr !== 7'h00)  begin errors++; $display("FAIL single_addr: got %h want 00", reg_addr); end
    checks++; if (reg_data !== 9'h097) begin errors++; $display("FAIL single_data: got %h want 097", reg_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_stop: got %b want 0", busy); end
    checks++; if (wv_cycles !== strobes) begin errors++; $display("FAIL single_pulse_width: got %0d cycles want %0d", wv_cycles, strobes); end
  endtask

  task automatic test_repeated_start();
    logic a0, a1, a2, a3, a4, a5;
    int base;
    base = strobes;
    i2c_start();
    send_byte(8'h34, a0); send_byte(8'h08, a1); send_byte(8'h15, a2);
    i2c_start();
    send_byte(8'h34, a3); send_byte(8'h12, a4); send_byte(8'h01, a5);
    i2c_stop();
    checks++; if ({a0, a1, a2, a3, a4, a5} !== 6'b111111) begin errors++; $display("FAIL rs_acks: got %b want 111111", {a0, a1, a2, a3, a4, a5}); end
    checks++; if (strobes - base !== 2) begin errors++; $display("FAIL rs_strobes: got %0d want 2", strobes - base); end
    if (strobes - base == 2) begin
      checks++; if (cap_addr[base] !== 7'd4 || cap_data[base] !== 9'h015)
        begin errors++; $display("FAIL rs_first: got (%h,%h) want (04,015)", cap_addr[base], cap_data[base]); end
      checks++; if (cap_addr[base+1] !== 7'd9 || cap_data[base+1] !== 9'h001)
        begin errors++; $display("FAIL rs_second: got (%h,%h) want (09,001)", cap_addr[base+1], cap_data[base+1]); end
    end
`ifdef I2C_RESP_SHADOW_EN
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL rs_active: got %b want 1", active); end
    rd_addr = 7'd4; #1;
    checks++; if (rd_data !== 9'h015) begin errors++; $display("FAIL rs_shadow4: got %h want 015", rd_data); end
    rd_addr = 7'd20; #1;
    checks++; if (rd_data !== 9'h000) begin errors++; $display("FAIL rs_shadow_oob: got %h want 000", rd_data); end
    @(negedge clk);
`endif
  endtask

  task automatic test_nack();
    logic a0, a1;
    int base;
    base = strobes;
    oe_seen = 1'b0;
    i2c_start();
    send_byte(8'h36, a0);
    i2c_start();
    send_byte(8'h35, a1);
    i2c_stop();
    checks++; if ({a0, a1} !== 2'b00) begin errors++; $display("FAIL nack_acks: got %b want 00", {a0, a1}); end
    checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL nack_oe_seen: got %b want 0", oe_seen); end
    checks++; if (strobes - base !== 0) begin errors++; $display("FAIL nack_strobes: got %0d want 0", strobes - base); end
    checks++; if (nack_cnt !== 8'd2) begin errors++; $display("FAIL nack_cnt: got %0d want 2", nack_cnt); end
  endtask

  task automatic test_abort();
    logic a0, a1;
    int base;
    base = strobes;
    i2c_start();
    send_byte(8'h34, a0);
    send_byte(8'h0E, a1);
    i2c_stop();
    checks++; if (strobes - base !== 0) begin errors++; $display("FAIL abort_strobes: got %0d want 0", strobes - base); end
    checks++; if (reg_addr !== 7'd9 || reg_data !== 9'h001)
      begin errors++; $display("FAIL abort_hold: got (%h,%h) want (09,001)", reg_addr, reg_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
  endtask

  task automatic test_extra_byte();
    logic a0, a1, a2, a3;
    int base;
    base = strobes;
    i2c_start();
    send_byte(8'h34, a0); send_byte(8'h0E, a1); send_byte(8'h42, a2); send_byte(8'hAA, a3);
    i2c_stop();
    checks++; if ({a0, a1, a2, a3} !== 4'b1110) begin errors++; $display("FAIL extra_acks: got %b want 1110", {a0, a1, a2, a3}); end
    checks++; if (strobes - base !== 1) begin errors++; $display("FAIL extra_strobes: got %0d want 1", strobes - base); end
    checks++; if (reg_addr !== 7'd7 || reg_data !== 9'h042)
      begin errors++; $display("FAIL extra_frame: got (%h,%h) want (07,042)", reg_addr, reg_data); end
  endtask

  task automatic test_reset_mid_frame();
    logic a0, a1, a2;
    int base;
    i2c_start();
    send_byte(8'h34, a0);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL mid_oe_before: got %b want 0", sda_oe); end
    rst = 1'b1;
    #20;
    checks++; if (sda_oe !== 1'b0 || wr_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL mid_ctrl: got oe=%b wv=%b busy=%b want 0,0,0", sda_oe, wr_valid, busy); end
    checks++; if (reg_addr !== 7'd0 || reg_data !== 9'd0 || nack_cnt !== 8'd0)
      begin errors++; $display("FAIL mid_regs: got (%h,%h,%0d) want (00,000,0)", reg_addr, reg_data, nack_cnt); end
    rst = 1'b0;
    @(negedge clk);
    i2c_stop();
    base = strobes;
    i2c_start();
    send_byte(8'h34, a0); send_byte(8'h10, a1); send_byte(8'h33, a2);
    i2c_stop();
    checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL mid_after_acks: got %b want 111", {a0, a1, a2}); end
    checks++; if (strobes - base !== 1 || reg_addr !== 7'd8 || reg_data !== 9'h033)
      begin errors++; $display("FAIL mid_after_frame: got n=%0d (%h,%h) want n=1 (08,033)", strobes - base, reg_addr, reg_data); end
`ifdef I2C_RESP_SHADOW_EN
    i2c_start();
    send_byte(8'h34, a0); send_byte(8'h12, a1); send_byte(8'h01, a2);
    i2c_stop();
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL shadow_active_set: got %b want 1", active); end
    i2c_start();
    send_byte(8'h34, a0); send_byte(8'h1E, a1); send_byte(8'h00, a2);
    i2c_stop();
    checks++; if (reg_addr !== 7'h0F) begin errors++; $display("FAIL shadow_reset_addr: got %h want 0f", reg_addr); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL shadow_active_clr: got %b want 0", active); end
    for (int r = 0; r < 16; r++) begin
      rd_addr = 7'(r); #1;
      checks++; if (rd_data !== 9'h000) begin errors++; $display("FAIL shadow_clr_%0d: got %h want 000", r, rd_data); end
    end
    @(negedge clk);
`endif
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_single_frame();
    test_repeated_start();
    test_nack();
    test_abort();
    test_extra_byte();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
